// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants, the coordinate type and
//               helpers that derive totals and sync window edges from the
//               four per-axis segment lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Horizontal segments in pixels, vertical segments in lines
    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;

    // Coordinate counters are 10 bits wide
    localparam int c_CNT_W   = 10;
    localparam int c_CNT_MAX = 1 << c_CNT_W;

    typedef logic [c_CNT_W-1:0] coord_t;

    // Positions in one period: active + front porch + sync + back porch
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First coordinate at which sync is asserted
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // First coordinate after the sync pulse (exclusive end)
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Timing bus between the pixel-timing generator and the GPU
//               character pipeline.
//               pix_en          pixel-slot enable (consumer -> generator)
//               x, y            pixel coordinates
//               h_sync, v_sync  sync pulses, configured polarity
//               active          visible-area qualifier
//               blanking_start  one-slot pulse at x=0 of the first blank line
//               frame           8-bit frame counter
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic       pix_en;
    coord_t     x;
    coord_t     y;
    logic       h_sync;
    logic       v_sync;
    logic       active;
    logic       blanking_start;
    logic [7:0] frame;

    // Generator side
    modport master (
        input  pix_en,
        output x, y, h_sync, v_sync, active, blanking_start, frame
    );

    // Consumer side
    modport slave (
        output pix_en,
        input  x, y, h_sync, v_sync, active, blanking_start, frame
    );

endinterface
`default_nettype wire

// File: rtl/vga_timing_gen_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Modulo-MODULUS up-counter.
//               clk, rst   clock, asynchronous active-high reset
//               en         advance enable
//               count      registered count, 0..MODULUS-1
//               count_nxt  value count takes at the next edge
//               wrap       count is at MODULUS-1 (wraps on next enabled edge)
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    output logic [WIDTH-1:0]      count,
    output logic [WIDTH-1:0]      count_nxt,
    output logic                  wrap
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    // The next value is exported so the parent can register decodes that
    // line up with the count on the same cycle.
    always_comb begin
        wrap      = (r_count == c_LAST);
        count_nxt = r_count;
        if (en) begin
            count_nxt = wrap ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= count_nxt;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Pixel-timing generator for the text-mode GPU. Produces pixel
//               coordinates, sync pulses, the active-video qualifier, a
//               start-of-vertical-blanking pulse and a frame counter.
//               clk   pixel clock (vgaClk)
//               rst   asynchronous active-high reset
//               vif   timing bus (master): pix_en in; x, y, h_sync, v_sync,
//                     active, blanking_start, frame out
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = c_H_ACTIVE,
    parameter int H_FP       = c_H_FP,
    parameter int H_SYNC     = c_H_SYNC,
    parameter int H_BP       = c_H_BP,
    parameter int V_ACTIVE   = c_V_ACTIVE,
    parameter int V_FP       = c_V_FP,
    parameter int V_SYNC     = c_V_SYNC,
    parameter int V_BP       = c_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vga_timing_gen_if.master vif
);

    localparam int c_H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Decode thresholds are 11 bits so an exclusive end of 1024 still fits
    localparam logic [10:0] c_HA       = 11'(H_ACTIVE);
    localparam logic [10:0] c_VA       = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START = 11'(sync_start(H_ACTIVE, H_FP));
    localparam logic [10:0] c_HS_END   = 11'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [10:0] c_VS_START = 11'(sync_start(V_ACTIVE, V_FP));
    localparam logic [10:0] c_VS_END   = 11'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    generate
        if (c_H_TOTAL > c_CNT_MAX || c_V_TOTAL > c_CNT_MAX) begin : g_bad_timing
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    coord_t     w_x;
    coord_t     w_x_nxt;
    coord_t     w_y;
    coord_t     w_y_nxt;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_v_en;
    logic [10:0] w_xe;
    logic [10:0] w_ye;

    logic       r_h_sync;
    logic       r_v_sync;
    logic       r_active;
    logic       r_blanking_start;
    logic [7:0] r_frame;

    assign w_v_en = vif.pix_en & w_h_wrap;

    wrap_counter #(
        .MODULUS (c_H_TOTAL),
        .WIDTH   (c_CNT_W)
    ) u_h_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (vif.pix_en),
        .count     (w_x),
        .count_nxt (w_x_nxt),
        .wrap      (w_h_wrap)
    );

    wrap_counter #(
        .MODULUS (c_V_TOTAL),
        .WIDTH   (c_CNT_W)
    ) u_v_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (w_v_en),
        .count     (w_y),
        .count_nxt (w_y_nxt),
        .wrap      (w_v_wrap)
    );

    // Decodes look at the counters' next values, so after the edge each
    // registered flag describes the coordinate registered on the same edge.
    assign w_xe = {1'b0, w_x_nxt};
    assign w_ye = {1'b0, w_y_nxt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_sync         <= ~H_SYNC_POL;
            r_v_sync         <= ~V_SYNC_POL;
            r_active         <= 1'b1;
            r_blanking_start <= 1'b0;
            r_frame          <= 8'd0;
        end else if (vif.pix_en) begin
            r_h_sync         <= (w_xe >= c_HS_START && w_xe < c_HS_END) ? H_SYNC_POL : ~H_SYNC_POL;
            r_v_sync         <= (w_ye >= c_VS_START && w_ye < c_VS_END) ? V_SYNC_POL : ~V_SYNC_POL;
            r_active         <= (w_xe < c_HA) && (w_ye < c_VA);
            r_blanking_start <= (w_x_nxt == '0) && (w_ye == c_VA);
            if (w_h_wrap && w_v_wrap) begin
                r_frame <= r_frame + 8'd1;
            end
        end
    end

    assign vif.x              = w_x;
    assign vif.y              = w_y;
    assign vif.h_sync         = r_h_sync;
    assign vif.v_sync         = r_v_sync;
    assign vif.active         = r_active;
    assign vif.blanking_start = r_blanking_start;
    assign vif.frame          = r_frame;

endmodule
`default_nettype wire
